// File: rtl/result_writer.sv
// Captures one frame of signed kernel results, clamps them to unsigned pixels and
// stores them in raster order in an on-chip frame buffer with an independent read port.
//   state   | meaning
//   IDLE    | waiting for start; counters hold last frame's totals
//   CAPTURE | writing one pixel per in_valid cycle
//   DONE    | single-cycle frame_done pulse, then back to IDLE
module result_writer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int IN_W  = 13,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             busy,
    output logic             frame_done,
    output logic [12:0]      pix_count,
    output logic [11:0]      clip_count,
    input  logic [11:0]      rd_addr,
    output logic [OUT_W-1:0] rd_data
);

    localparam int          DEPTH     = IMG_W * IMG_H;
    localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [11:0]      r_wr_addr;
    logic [12:0]      r_pix_count;
    logic [11:0]      r_clip_count;
    logic [OUT_W-1:0] r_rd_data;
    logic [OUT_W-1:0] r_mem [DEPTH];

    logic             w_start_frame;
    logic             w_wr_en;
    logic             w_neg;
    logic             w_over;
    logic             w_clip;
    logic [OUT_W-1:0] w_clamped;

    // Positive results overflow when any magnitude bit above the pixel width is set.
    assign w_neg     = in_data[IN_W-1];
    assign w_over    = !w_neg && (|in_data[IN_W-2:OUT_W]);
    assign w_clip    = w_neg || w_over;
    assign w_clamped = w_neg ? '0 : (w_over ? '1 : in_data[OUT_W-1:0]);

    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_wr_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_addr == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_addr    <= '0;
            r_pix_count  <= '0;
            r_clip_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_frame) begin
                r_wr_addr    <= '0;
                r_pix_count  <= '0;
                r_clip_count <= '0;
            end else if (w_wr_en) begin
                r_wr_addr   <= (r_wr_addr == LAST_ADDR) ? 12'd0 : r_wr_addr + 12'd1;
                r_pix_count <= r_pix_count + 13'd1;
                if (w_clip && (r_clip_count != 12'hFFF)) begin
                    r_clip_count <= r_clip_count + 12'd1;
                end
            end
        end
    end

    // Frame buffer is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_clamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign busy       = (r_state == S_CAPTURE);
    assign frame_done = (r_state == S_DONE);
    assign pix_count  = r_pix_count;
    assign clip_count = r_clip_count;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: a memory model plus a read scoreboard queue
// track expected pixels; frame sequencing, clamping, reset and read timing are exercised.
module tb_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [12:0] in_data;
    logic        busy;
    logic        frame_done;
    logic [12:0] pix_count;
    logic [11:0] clip_count;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;

    result_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_count  (pix_count),
        .clip_count (clip_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_done   = 0;
    logic [7:0] m_mem [4096];
    int         m_wa;
    int         m_pix;
    int         m_clip;
    logic [7:0] rd_q [$];

    always @(negedge clk) if (frame_done === 1'b1) n_done++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] clamp(input logic [12:0] d);
        logic signed [12:0] s;
        s = d;
        if (s < 0)   return 8'd0;
        if (s > 255) return 8'd255;
        return d[7:0];
    endfunction

    function automatic bit is_clip(input logic [12:0] d);
        logic signed [12:0] s;
        s = d;
        return (s < 0) || (s > 255);
    endfunction

    // One clock: drive inputs, update the model for an expected write, score the read.
    task automatic cyc(input bit v, input logic [12:0] d, input bit do_wr,
                       input bit do_rd, input logic [11:0] ra);
        logic [7:0] exp;
        in_valid = v;
        in_data  = d;
        rd_addr  = ra;
        if (do_rd) rd_q.push_back(m_mem[ra]);
        if (do_wr) begin
            m_mem[m_wa] = clamp(d);
            m_wa        = (m_wa + 1) % 4096;
            m_pix++;
            if (is_clip(d) && m_clip < 4095) m_clip++;
        end
        step;
        if (do_rd) begin
            exp = rd_q.pop_front();
            check("rd_data", int'(rd_data), int'(exp));
        end
    endtask

    task automatic start_frame;
        start    = 1'b1;
        in_valid = 1'b0;
        step;
        start  = 1'b0;
        m_wa   = 0;
        m_pix  = 0;
        m_clip = 0;
        check("busy_after_start", int'(busy), 1);
        check("pix_cleared", int'(pix_count), 0);
        check("clip_cleared", int'(clip_count), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pix"}, int'(pix_count), m_pix);
        check({tag, "_clip"}, int'(clip_count), m_clip);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int ncyc;
        int wr_i;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
        #2 rst = 1'b1;
        #10;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_pix", int'(pix_count), 0);
        check("rst_clip", int'(clip_count), 0);
        check("rst_rd_data", int'(rd_data), 0);
        @(negedge clk) rst = 1'b0;
        step;
        check("idle_after_rst", int'(busy), 0);

        // Full frame with address-mod-256 data
        start_frame;
        d0 = n_done;
        for (int i = 0; i < 4096; i++) begin
            cyc(1'b1, 13'(i % 256), 1'b1, 1'b0, 12'd0);
            if (i == 4094) check("done_early", int'(frame_done), 0);
        end
        check("f1_done", int'(frame_done), 1);
        check("f1_busy", int'(busy), 0);
        check_counts("f1");
        check("f1_pix_4096", int'(pix_count), 4096);
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd300);
        check("rd300", int'(rd_data), 44);
        check("f1_done_once", n_done - d0, 1);
        check("f1_done_cleared", int'(frame_done), 0);
        check_counts("f1_hold");

        // Clamping, then a random remainder of the frame
        start_frame;
        cyc(1'b1, 13'h1FFB, 1'b1, 1'b0, 12'd0);
        cyc(1'b1, 13'd300, 1'b1, 1'b0, 12'd0);
        cyc(1'b1, 13'd255, 1'b1, 1'b0, 12'd0);
        check("clip_two", int'(clip_count), 2);
        check_counts("clamp");
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd0);
        check("clamp_neg", int'(rd_data), 0);
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd1);
        check("clamp_hi", int'(rd_data), 255);
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd2);
        check("clamp_255", int'(rd_data), 255);
        for (int i = 3; i < 4096; i++)
            cyc(1'b1, 13'($urandom_range(0, 8191)), 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
        check("f2_done", int'(frame_done), 1);
        check_counts("f2");
        start = 1'b1;
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'($urandom_range(0, 4095)));
        start = 1'b0;
        check("start_in_done_ignored", int'(busy), 0);

        // Start right after DONE, then in_valid toggling every cycle
        start_frame;
        ncyc = 0;
        wr_i = 0;
        while (frame_done !== 1'b1 && ncyc < 9000) begin
            if ((ncyc % 2 == 0) && m_pix < 4096) begin
                cyc(1'b1, 13'((wr_i * 37 + 5) % 256), 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
                wr_i++;
            end else begin
                cyc(1'b0, 13'h0AA, 1'b0, 1'b1, 12'($urandom_range(0, 4095)));
            end
            ncyc++;
        end
        check("toggle_done_latency", ncyc, 8191);
        check_counts("f3");
        for (int a = 0; a < 4096; a += 511) cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'(a));

        // start re-pulsed mid-frame
        start_frame;
        d0 = n_done;
        for (int i = 0; i < 4096; i++) begin
            start = (i == 100);
            cyc(1'b1, 13'((i * 11) % 256), 1'b1, 1'b0, 12'd0);
            if (i == 100) begin
                check("restart_ignored_pix", int'(pix_count), 101);
                check("restart_ignored_busy", int'(busy), 1);
            end
        end
        start = 1'b0;
        check("f4_done", int'(frame_done), 1);
        check_counts("f4");
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd101);
        check("f4_done_once", n_done - d0, 1);

        // Reset after 2000 writes
        start_frame;
        for (int i = 0; i < 2000; i++)
            cyc(1'b1, 13'((i == 10) ? 3 : (i * 3 + 1) % 256), 1'b1, 1'b0, 12'd0);
        in_valid = 1'b0;
        d0 = n_done;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_pix", int'(pix_count), 0);
        check("abort_clip", int'(clip_count), 0);
        check("abort_rd_data", int'(rd_data), 0);
        @(negedge clk) rst = 1'b0;
        m_wa = 0; m_pix = 0; m_clip = 0;
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd1999);
        check("mem1999_kept", int'(rd_data), (1999 * 3 + 1) % 256);
        cyc(1'b1, 13'd99, 1'b0, 1'b1, 12'd5);
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd5);
        check("idle_ignores_valid", int'(busy), 0);
        check("abort_no_done", n_done - d0, 0);

        // Read-during-write returns old contents
        start_frame;
        for (int i = 0; i < 10; i++) cyc(1'b1, 13'(50 + i), 1'b1, 1'b0, 12'd0);
        cyc(1'b1, 13'd7, 1'b1, 1'b1, 12'd10);
        check("rdw_old", int'(rd_data), 3);
        cyc(1'b0, 13'd0, 1'b0, 1'b1, 12'd10);
        check("rdw_new", int'(rd_data), 7);
        check_counts("f6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_W, 64, image width in pixels.
- IMG_H, 64, image height in pixels.
- IN_W, 13, kernel result width, two's complement.
- OUT_W, 8, stored pixel width, unsigned.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle request to begin capturing a frame.
- in_valid, input, 1, in_data is a valid kernel result this cycle.
- in_data, input, IN_W, signed kernel result from the 3x3 stage.
- busy, output, 1, high while capturing a frame.
- frame_done, output, 1, one-cycle pulse after the last pixel is written.
- pix_count, output, 13, number of pixels written in the current or last frame.
- clip_count, output, 12, number of clamped results in the current or last frame; saturates at 4095.
- rd_addr, input, 12, read address of the output frame buffer.
- rd_data, output, OUT_W, registered read data.

Function
REQ-003 The block SHALL contain an IMG_W*IMG_H x OUT_W frame buffer with one write port and one independent read port.
REQ-004 FSM states SHALL be IDLE, CAPTURE and DONE.
REQ-005 IDLE: start=1 SHALL move to CAPTURE and clear wr_addr, pix_count and clip_count to 0 in the same edge.
REQ-006 IDLE and DONE SHALL ignore in_valid; no write occurs.
REQ-007 CAPTURE: each cycle with in_valid=1 SHALL write clamp(in_data) to mem[wr_addr] and increment wr_addr and pix_count.
REQ-008 CAPTURE cycles with in_valid=0 SHALL leave memory and all counters unchanged; gaps of any length are legal.
REQ-009 Clamp rule:
- in_data < 0 -> 0.
- in_data > 255 -> 255.
- otherwise in_data[7:0].
REQ-010 Each clamped value SHALL increment clip_count, which holds at 4095 once reached.
REQ-011 The write at wr_addr = IMG_W*IMG_H-1 SHALL move the FSM to DONE on the same edge; wr_addr SHALL wrap to 0.
REQ-012 DONE SHALL last exactly one cycle with frame_done=1, then return to IDLE.
REQ-013 busy SHALL be 1 in CAPTURE only.
REQ-014 start asserted in CAPTURE or DONE SHALL be ignored.
REQ-015 start asserted in the IDLE cycle directly after DONE SHALL begin a new frame.
REQ-016 pix_count and clip_count SHALL hold their final values in IDLE until the next start.
REQ-017 Read path:
- rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented, in every state.
- Reading the address being written in the same cycle SHALL return the old contents.
REQ-018 Write address ordering SHALL be raster order: address = row*IMG_W + col.

Reset
REQ-019 rst=1 SHALL immediately force the FSM to IDLE and set busy=0, frame_done=0, pix_count=0, clip_count=0, wr_addr=0 and rd_data=0.
REQ-020 Frame buffer contents SHALL NOT be cleared by reset.
REQ-021 Reset asserted mid-CAPTURE SHALL abandon the frame.
- No frame_done is issued for the abandoned frame.
- Pixels already written remain in the frame buffer.
REQ-022 The first edge after rst deasserts SHALL act as a normal IDLE cycle.

Verification
REQ-023 start, then 4096 consecutive in_valid with in_data = address mod 256 -> frame_done pulses exactly one cycle after the 4096th write; pix_count=4096; clip_count=0; readback of addr 300 gives 44.
REQ-024 In CAPTURE, in_data = -5 (0x1FFB), then 300, then 255 -> stored values 0, 255, 255; clip_count=2.
REQ-025 in_valid toggled 1/0 every cycle throughout a frame -> all 4096 pixels written in order; frame_done occurs 8191 cycles after the first write.
REQ-026 start re-pulsed at pixel 100 of a frame -> no restart; frame completes normally; pix_count=4096.
REQ-027 rst asserted after 2000 writes -> busy=0 and pix_count=0 immediately; no frame_done; mem[1999] retains its written value.
REQ-028 In the same cycle, write mem[10]=7 while rd_addr=10, with the old value 3 -> rd_data=3 next cycle and 7 the cycle after.
